// File: rtl/reg_ctx_sequencer_if.sv
// Bus bundle for reg_ctx_sequencer: command inputs, register-bank port,
// data-memory port and status. The Checksum signal exists only when
// CTX_CHECKSUM_EN is defined.
interface reg_ctx_sequencer_if #(
  parameter int NUM_REGS = 64
) ();
  localparam int IDX_W = $clog2(NUM_REGS);

  // Command
  logic             Start;
  logic             Mode;
  logic [IDX_W-1:0] First_Reg;
  logic [IDX_W-1:0] Last_Reg;
  logic [31:0]      Base_Addr;

  // Register bank port
  logic [IDX_W-1:0] Reg_Sel;
  logic [31:0]      Reg_Data;
  logic             Reg_Write;
  logic [31:0]      Reg_Write_Data;

  // Data memory port
  logic [31:0]      Mem_Addr;
  logic             Mem_Write;
  logic [31:0]      Mem_Write_Data;
  logic             Mem_Read;
  logic [31:0]      Mem_Read_Data;
  logic             Mem_Ready;

  // Status
  logic             Busy;
  logic             Done;
  logic             Error;
`ifdef CTX_CHECKSUM_EN
  logic [31:0]      Checksum;
`endif

  // Sequencer side
  modport slave (
    input  Start, Mode, First_Reg, Last_Reg, Base_Addr,
    input  Reg_Data, Mem_Read_Data, Mem_Ready,
    output Reg_Sel, Reg_Write, Reg_Write_Data,
    output Mem_Addr, Mem_Write, Mem_Write_Data, Mem_Read,
    output Busy, Done, Error
`ifdef CTX_CHECKSUM_EN
    , output Checksum
`endif
  );

  // Core / bank / memory side
  modport master (
    output Start, Mode, First_Reg, Last_Reg, Base_Addr,
    output Reg_Data, Mem_Read_Data, Mem_Ready,
    input  Reg_Sel, Reg_Write, Reg_Write_Data,
    input  Mem_Addr, Mem_Write, Mem_Write_Data, Mem_Read,
    input  Busy, Done, Error
`ifdef CTX_CHECKSUM_EN
    , input  Checksum
`endif
  );
endinterface

// File: rtl/reg_ctx_sequencer.sv
// Context save/restore engine for the register bank. Streams the register
// range First_Reg..Last_Reg to data memory (Mode=0) or back from memory into
// the bank (Mode=1). Register 0 is never written on restore.
// Optional feature: define CTX_CHECKSUM_EN to add an XOR checksum of every
// transferred word on the Checksum output.
module reg_ctx_sequencer #(
  parameter int          NUM_REGS    = 64,
  parameter int unsigned ADDR_STRIDE = 1
) (
  input logic                Slow_Clock,
  input logic                Reset,
  reg_ctx_sequencer_if.slave bus
);
  localparam int          IDX_W  = $clog2(NUM_REGS);
  localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    REST_RD = 3'd2,
    REST_WR = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
`ifdef CTX_CHECKSUM_EN
  logic [31:0]      cs_q, cs_d;
`endif

  logic [IDX_W-1:0] reg_sel;
  logic             reg_write;
  logic [31:0]      reg_wdata;
  logic [31:0]      mem_addr;
  logic             mem_write;
  logic [31:0]      mem_wdata;
  logic             mem_read;
  logic             done;
  logic             error;

  // State, cursor, address and capture registers; synchronous reset clears all
  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
`ifdef CTX_CHECKSUM_EN
      cs_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
`ifdef CTX_CHECKSUM_EN
      cs_q     <= cs_d;
`endif
    end
  end

  // Next-state and output decode; the end-of-range test precedes the
  // increment so Last_Reg = NUM_REGS-1 finishes without wrapping
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    last_d    = last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
`ifdef CTX_CHECKSUM_EN
    cs_d      = cs_q;
`endif
    reg_sel   = '0;
    reg_write = 1'b0;
    reg_wdata = '0;
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
`ifdef CTX_CHECKSUM_EN
          cs_d = '0;
`endif
          if (bus.First_Reg > bus.Last_Reg) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d    = 1'b0;
            cursor_d = bus.First_Reg;
            last_d   = bus.Last_Reg;
            addr_d   = bus.Base_Addr;
            state_d  = bus.Mode ? REST_RD : SAVE;
          end
        end
      end

      SAVE: begin
        reg_sel   = cursor_q;
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = bus.Reg_Data;
        if (bus.Mem_Ready) begin
`ifdef CTX_CHECKSUM_EN
          cs_d = cs_q ^ bus.Reg_Data;
`endif
          if (cursor_q == last_q) begin
            state_d = DONE;
          end else begin
            cursor_d = cursor_q + IDX_W'(1);
            addr_d   = addr_q + STRIDE;
          end
        end
      end

      REST_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        if (bus.Mem_Ready) begin
          data_d  = bus.Mem_Read_Data;
`ifdef CTX_CHECKSUM_EN
          cs_d    = cs_q ^ bus.Mem_Read_Data;
`endif
          state_d = REST_WR;
        end
      end

      REST_WR: begin
        reg_sel   = cursor_q;
        reg_wdata = data_q;
        reg_write = (cursor_q != '0);
        if (cursor_q == last_q) begin
          state_d = DONE;
        end else begin
          cursor_d = cursor_q + IDX_W'(1);
          addr_d   = addr_q + STRIDE;
          state_d  = REST_RD;
        end
      end

      DONE: begin
        done    = 1'b1;
        error   = err_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.Reg_Sel        = reg_sel;
  assign bus.Reg_Write      = reg_write;
  assign bus.Reg_Write_Data = reg_wdata;
  assign bus.Mem_Addr       = mem_addr;
  assign bus.Mem_Write      = mem_write;
  assign bus.Mem_Write_Data = mem_wdata;
  assign bus.Mem_Read       = mem_read;
  assign bus.Busy           = (state_q != IDLE);
  assign bus.Done           = done;
  assign bus.Error          = error;
`ifdef CTX_CHECKSUM_EN
  assign bus.Checksum       = cs_q;
`endif

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Testbench for reg_ctx_sequencer: bank and memory models, a stall-capable
// memory responder, a transfer scoreboard and a table of command vectors,
// plus hand-written reset and initial-state sequences.
`timescale 1ns/1ps
module tb_reg_ctx_sequencer;
  logic Slow_Clock = 1'b0;
  logic Reset;

  always #5 Slow_Clock = ~Slow_Clock;

  reg_ctx_sequencer_if #(.NUM_REGS(64)) bus ();

  reg_ctx_sequencer #(.NUM_REGS(64), .ADDR_STRIDE(1)) dut (
    .Slow_Clock (Slow_Clock),
    .Reset      (Reset),
    .bus        (bus)
  );

  logic [31:0] bank [64];
  logic [31:0] mem  [4096];
  int          cur_stall;
  int          wait_cnt = 0;

  assign bus.Reg_Data      = bank[bus.Reg_Sel];
  assign bus.Mem_Read_Data = mem[bus.Mem_Addr[11:0]];
  assign bus.Mem_Ready     = (bus.Mem_Write | bus.Mem_Read) && (wait_cnt >= cur_stall);

  // Memory responder: holds Mem_Ready low for cur_stall cycles per request
  always @(posedge Slow_Clock) begin
    if ((bus.Mem_Write | bus.Mem_Read) && !bus.Mem_Ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  typedef struct {
    bit          is_reg;
    logic [31:0] where;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    bit          mode;
    int          first;
    int          last;
    logic [31:0] base;
    int          stall;
    int          poke;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  vecs[9];
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pop_check(input bit is_reg, input logic [31:0] where, input logic [31:0] data);
    xfer_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_xfer", where, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("xfer_kind", 32'(is_reg), 32'(e.is_reg));
      check(is_reg ? "reg_index" : "mem_addr", where, e.where);
      check(is_reg ? "reg_wdata" : "mem_wdata", data, e.data);
    end
  endtask

  // Observes the DUT every cycle mid-period and consumes scoreboard entries
  task automatic monitor();
    logic [31:0] prev_addr = '0;
    bit          stalled   = 1'b0;
    bit          prev_rw   = 1'b0;
    forever begin
      @(negedge Slow_Clock);
      if (stalled && (bus.Mem_Write | bus.Mem_Read))
        check("addr_stable", bus.Mem_Addr, prev_addr);
      stalled   = (bus.Mem_Write | bus.Mem_Read) && !bus.Mem_Ready;
      prev_addr = bus.Mem_Addr;
      if (bus.Mem_Write && bus.Mem_Read) check("rd_wr_exclusive", 32'd1, 32'd0);
      if (bus.Reg_Write) begin
        check("rw_one_cycle", 32'(prev_rw), 32'd0);
        check("rw_not_r0", 32'(bus.Reg_Sel != 6'd0), 32'd1);
        pop_check(1'b1, 32'(bus.Reg_Sel), bus.Reg_Write_Data);
      end
      prev_rw = bus.Reg_Write;
      if (bus.Mem_Write && bus.Mem_Ready) pop_check(1'b0, bus.Mem_Addr, bus.Mem_Write_Data);
      if (bus.Error) check("error_with_done", 32'(bus.Done), 32'd1);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {26'd0, bus.Busy, bus.Done, bus.Error, bus.Reg_Write, bus.Mem_Write, bus.Mem_Read}, 32'd0);
    check({name, "_sel"}, 32'(bus.Reg_Sel), 32'd0);
    check({name, "_addr"}, bus.Mem_Addr, 32'd0);
    check({name, "_rwd"}, bus.Reg_Write_Data, 32'd0);
    check({name, "_mwd"}, bus.Mem_Write_Data, 32'd0);
  endtask

  // Builds the expected transfer list for a command; returns the XOR of all words moved
  task automatic expect_xfers(input vec_t v, output logic [31:0] cs);
    logic [31:0] a;
    logic [31:0] w;
    cs = '0;
    for (int i = v.first; i <= v.last; i++) begin
      a = v.base + 32'(i - v.first);
      if (!v.mode) begin
        w = bank[i];
        exp_q.push_back('{1'b0, a, w});
      end else begin
        w = mem[a[11:0]];
        if (i != 0) exp_q.push_back('{1'b1, 32'(i), w});
      end
      cs = cs ^ w;
    end
  endtask

  task automatic issue(input vec_t v);
    @(posedge Slow_Clock); #1;
    cur_stall     = v.stall;
    bus.Start     = 1'b1;
    bus.Mode      = v.mode;
    bus.First_Reg = 6'(v.first);
    bus.Last_Reg  = 6'(v.last);
    bus.Base_Addr = v.base;
    @(negedge Slow_Clock);
    check("busy_cycle0", 32'(bus.Busy), 32'd0);
    @(posedge Slow_Clock); #1;
    bus.Start     = 1'b0;
    bus.First_Reg = 6'($urandom);
    bus.Last_Reg  = 6'($urandom);
    bus.Base_Addr = $urandom;
  endtask

  task automatic run_vector(input vec_t v);
    logic [31:0] cs;
    int          done_cyc = 0;
    logic        err_seen = 1'b0;
    expect_xfers(v, cs);
    issue(v);
    for (int k = 1; k <= 400; k++) begin
      if (v.poke != 0 && k == v.poke) begin
        bus.Start     = 1'b1;
        bus.Mode      = ~v.mode;
        bus.First_Reg = 6'd50;
        bus.Last_Reg  = 6'd60;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge Slow_Clock);
      check("busy", 32'(bus.Busy), 32'd1);
      if (v.exp_err)
        check("illegal_no_xfer", 32'({bus.Mem_Write, bus.Mem_Read, bus.Reg_Write}), 32'd0);
      if (bus.Done) begin
        done_cyc = k;
        err_seen = bus.Error;
`ifdef CTX_CHECKSUM_EN
        if (!v.exp_err) check("checksum", bus.Checksum, cs);
`endif
        break;
      end
      @(posedge Slow_Clock); #1;
    end
    bus.Start = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    check("error", 32'(err_seen), 32'(v.exp_err));
    @(posedge Slow_Clock); #1;
    @(negedge Slow_Clock);
    check("done_pulse_end", 32'({bus.Done, bus.Busy, bus.Error}), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef CTX_CHECKSUM_EN
    if (!v.exp_err) check("checksum_hold", bus.Checksum, cs);
`endif
    exp_q.delete();
  endtask

  // Restore of 10 registers aborted by Reset during the third read
  task automatic reset_mid_restore();
    vec_t        v;
    logic [31:0] cs;
    v = '{1'b1, 30, 39, 32'h600, 0, 0, 1'b0, 21};
    expect_xfers(v, cs);
    issue(v);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Slow_Clock);
      check("rst_seq_busy", 32'(bus.Busy), 32'd1);
      @(posedge Slow_Clock); #1;
    end
    Reset = 1'b1;
    @(posedge Slow_Clock); #1;
    Reset = 1'b0;
    @(negedge Slow_Clock);
    check_all_zero("mid_reset_idle");
`ifdef CTX_CHECKSUM_EN
    check("mid_reset_cs", bus.Checksum, 32'd0);
`endif
    check("mid_reset_consumed", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge Slow_Clock);
      check("post_reset_quiet", 32'({bus.Busy, bus.Reg_Write, bus.Mem_Write, bus.Mem_Read}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) bank[i] = 32'hA500_0000 + 32'(i) * 32'h101;
    bank[1] = 32'h11;
    bank[2] = 32'h22;
    bank[3] = 32'h33;
    bank[7] = 32'h0F;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h200] = 32'hAAAA;
    mem[12'h201] = 32'h5555;
    mem[12'h300] = 32'hDEAD;
    mem[12'h301] = 32'hBEEF;
    for (int k = 0; k < 6; k++)  mem[12'h500 + 12'(k)] = 32'h1234_0000 + 32'(k);
    for (int k = 0; k < 10; k++) mem[12'h600 + 12'(k)] = 32'h6000_0000 + 32'(k);

    //          mode  first last base           stall poke err  done
    vecs[0] = '{1'b0,  1,   3, 32'h0000_0100,  0,    0,  1'b0,  4};
    vecs[1] = '{1'b0,  7,   7, 32'h0000_0700,  0,    0,  1'b0,  2};
    vecs[2] = '{1'b1, 40,  41, 32'h0000_0200,  2,    0,  1'b0,  9};
    vecs[3] = '{1'b1,  0,   1, 32'h0000_0300,  0,    0,  1'b0,  5};
    vecs[4] = '{1'b0,  5,   4, 32'h0000_0800,  0,    0,  1'b1,  1};
    vecs[5] = '{1'b0, 63,  63, 32'h0000_0400,  0,    0,  1'b0,  2};
    vecs[6] = '{1'b0, 10,  12, 32'hFFFF_FFFF,  1,    0,  1'b0,  7};
    vecs[7] = '{1'b1, 20,  25, 32'h0000_0500,  1,    0,  1'b0, 19};
    vecs[8] = '{1'b0,  1,   3, 32'h0000_0900,  0,    2,  1'b0,  4};

    cur_stall     = 0;
    Reset         = 1'b1;
    bus.Start     = 1'b0;
    bus.Mode      = 1'b0;
    bus.First_Reg = '0;
    bus.Last_Reg  = '0;
    bus.Base_Addr = '0;

    fork
      monitor();
    join_none

    repeat (2) @(posedge Slow_Clock);
    @(negedge Slow_Clock);
    check_all_zero("in_reset");
    @(posedge Slow_Clock); #1;
    Reset = 1'b0;
    @(negedge Slow_Clock);
    check_all_zero("after_reset");
`ifdef CTX_CHECKSUM_EN
    check("reset_cs", bus.Checksum, 32'd0);
`endif

    for (int i = 0; i < 9; i++) run_vector(vecs[i]);

    reset_mid_restore();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
